vc_fifo: RTL and testbench
==========================

VC_FIFO -- requirements
Module: vc_fifo

Interface
- REQ-001 Parameter NUM_VC, default 2: number of virtual channels; legal range 2..16.
- REQ-002 Parameter ADDR_WIDTH, default 3: per-VC depth is 2**ADDR_WIDTH entries.
- REQ-003 Parameter DATA_WIDTH, default 32: flit width in bits.
- REQ-004 clk  input  1: the single clock; all state updates on its rising edge.
- REQ-005 reset  input  1: synchronous, active-high reset.
- REQ-006 push  input  1: write request.
- REQ-007 push_vc  input  $clog2(NUM_VC): target VC of the write.
- REQ-008 din  input  DATA_WIDTH: write data.
- REQ-009 pop  input  1: read request.
- REQ-010 pop_vc  input  $clog2(NUM_VC): VC being read and shown on dout.
- REQ-011 dout  output  DATA_WIDTH: head entry of VC pop_vc.
- REQ-012 empty  output  NUM_VC: per-VC empty flag.
- REQ-013 full  output  NUM_VC: per-VC full flag.
- REQ-014 drop  output  1: registered one-cycle pulse when a push was discarded.
- REQ-015 count  output  NUM_VC*(ADDR_WIDTH+1): per-VC occupancy; present only with VC_FIFO_COUNT_EN.

Function
- REQ-016 Each VC is an independent circular FIFO with its own read pointer, write pointer and occupancy.
- REQ-017 dout is first-word-fall-through: the combinational head of pop_vc, valid in the same cycle pop_vc changes.
- REQ-018 dout is undefined while VC pop_vc is empty.
- REQ-019 A push to a non-full VC writes din at that VC's write pointer; the entry is visible on dout from the next cycle.
- REQ-020 A pop of a non-empty VC advances that VC's read pointer at the clock edge.
- REQ-021 A pop of an empty VC is ignored; no state changes.
- REQ-022 A push to a full VC is discarded and drop pulses in the next cycle, unless the same cycle pops that same VC.
- REQ-023 Push and pop of the same full VC in one cycle are both accepted; full stays 1 and occupancy is unchanged.
- REQ-024 Push and pop of the same empty VC in one cycle: push accepted, pop ignored, with no bypass to dout.
- REQ-025 Push and pop of different VCs in one cycle proceed independently.
- REQ-026 Pointers wrap modulo 2**ADDR_WIDTH; occupancy is ADDR_WIDTH+1 bits wide; full means occupancy == 2**ADDR_WIDTH, empty means occupancy == 0.
- REQ-027 empty and full are registered or derived from registered occupancy only; they never depend combinationally on push or pop.
- REQ-028 push_vc or pop_vc values of NUM_VC or above: the request is ignored, and an ignored push also pulses drop.

Reset
- REQ-029 While reset is 1 at a rising edge, all pointers and occupancies clear to 0.
- REQ-030 Reset values: empty all 1, full all 0, drop 0, count all 0.
- REQ-031 Reset has priority over a simultaneous push or pop, and flushes data mid-operation.
- REQ-032 Storage contents are not reset.

Configuration
- REQ-033 Macro VC_FIFO_COUNT_EN: when defined, the count port exists and carries per-VC occupancy, with VC v at bits [v*(ADDR_WIDTH+1) +: ADDR_WIDTH+1].
- REQ-034 Without VC_FIFO_COUNT_EN, the count port is absent; all other behaviour is identical.

Structure
- REQ-035 Shared package noc_pkg holds the default constants NUM_VC_DEF, FIFO_ADDR_WIDTH_DEF and FLIT_WIDTH_DEF, plus the flit_t typedef.
- REQ-036 One sub-module, vc_fifo_ctrl, holds the pointers, occupancy and empty/full for a single VC, instantiated NUM_VC times.
- REQ-037 Storage is a single array indexed by {vc, pointer} in the top level.

Verification
- REQ-038 Scenario (NUM_VC=2, ADDR_WIDTH=3, DATA_WIDTH=32): reset -> empty=2'b11, full=2'b00, drop=0.
- REQ-039 Scenario: push 0..7 to VC0 -> full[0]=1, empty[1]=1; then push 8 -> drop=1 next cycle; dout (pop_vc=0) = 0.
- REQ-040 Scenario: VC0 full, push 8 and pop VC0 in one cycle -> full[0] stays 1; dout = 1; subsequent pops return 1..8, then empty[0]=1.
- REQ-041 Scenario: push 0xA to VC1 while popping non-empty VC0 -> both accepted; with pop_vc=1, dout = 0xA next cycle; count for VC1 = 1 with VC_FIFO_COUNT_EN.
- REQ-042 Scenario: push and pop the same empty VC1 in one cycle -> empty[1]=0 next cycle, and the pushed value is still present.
- REQ-043 Scenario: assert reset with 5 entries in VC0 -> empty[0]=1 next cycle; a pop of VC0 afterwards changes nothing.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared constants and types for the NoC buffering blocks.
//
// Contents:
//   NUM_VC_DEF           default number of virtual channels
//   FIFO_ADDR_WIDTH_DEF  default per-VC FIFO address width (depth = 2**width)
//   FLIT_WIDTH_DEF       default flit width in bits
//   flit_t               flit type at the default width
package noc_pkg;

  localparam int NUM_VC_DEF          = 2;
  localparam int FIFO_ADDR_WIDTH_DEF = 3;
  localparam int FLIT_WIDTH_DEF      = 32;

  typedef logic [FLIT_WIDTH_DEF-1:0] flit_t;

endpackage

// File: rtl/vc_fifo_ctrl.sv
// vc_fifo_ctrl: pointer and occupancy bookkeeping for a single virtual channel.
//
// The caller qualifies push/pop so that they are asserted only when this VC is
// the target. The block decides which requests are accepted and keeps the
// read/write pointers and occupancy. empty/full come only from registered
// occupancy, so they never depend combinationally on push or pop.
//
// Optional feature: when VC_FIFO_COUNT_EN is defined, the occupancy port is
// present.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   push       write request aimed at this VC
//   pop        read request aimed at this VC
//   wr_ptr     slot the next accepted push writes
//   rd_ptr     slot holding the current head entry
//   empty      occupancy == 0
//   full       occupancy == 2**ADDR_WIDTH
//   push_ok    this cycle's push is accepted (storage write enable)
//   occupancy  current entry count (only with VC_FIFO_COUNT_EN)
module vc_fifo_ctrl #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic                  empty,
  output logic                  full,
  output logic                  push_ok
`ifdef VC_FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   occupancy
`endif
);

  localparam logic [ADDR_WIDTH:0] FULL_OCC = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0] occ;
  logic                pop_ok;

  assign empty = (occ == '0);
  assign full  = (occ == FULL_OCC);

  // A full VC still takes a push when the same cycle pops it: the pop frees
  // the slot the push fills. An empty VC never honours a pop, even when a push
  // arrives in the same cycle, so there is no bypass path.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

`ifdef VC_FIFO_COUNT_EN
  assign occupancy = occ;
`endif

  // Pointers wrap naturally at 2**ADDR_WIDTH; occupancy is one bit wider so
  // that full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/vc_fifo.sv
// vc_fifo: multi-virtual-channel FIFO with shared storage.
//
// Each VC is an independent circular FIFO of 2**ADDR_WIDTH entries. All VCs
// share one storage array addressed by {vc, pointer}. dout is
// first-word-fall-through: it shows the head of VC pop_vc combinationally and
// is undefined while that VC is empty.
//
// Optional feature: define VC_FIFO_COUNT_EN to add the count port.
//
// Ports:
//   clk      clock, rising edge
//   reset    synchronous, active-high; clears pointers and occupancy only
//   push     write request
//   push_vc  target VC of the write
//   din      write data
//   pop      read request
//   pop_vc   VC being read and shown on dout
//   dout     head entry of VC pop_vc
//   empty    per-VC empty flags
//   full     per-VC full flags
//   drop     registered one-cycle pulse after a discarded push
//   count    per-VC occupancy, VC v at [v*(ADDR_WIDTH+1) +: ADDR_WIDTH+1]
//            (only with VC_FIFO_COUNT_EN)
module vc_fifo
  import noc_pkg::*;
#(
  parameter int NUM_VC     = NUM_VC_DEF,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = FLIT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [$clog2(NUM_VC)-1:0] push_vc,
  input  logic [DATA_WIDTH-1:0]     din,
  input  logic                      pop,
  input  logic [$clog2(NUM_VC)-1:0] pop_vc,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic [NUM_VC-1:0]         empty,
  output logic [NUM_VC-1:0]         full,
  output logic                      drop
`ifdef VC_FIFO_COUNT_EN
  ,
  output logic [NUM_VC*(ADDR_WIDTH+1)-1:0] count
`endif
);

  localparam int VC_W        = $clog2(NUM_VC);
  localparam int DEPTH       = 1 << ADDR_WIDTH;
  // Sized to the full {vc, pointer} address space so that an out-of-range
  // pop_vc still indexes inside the array (dout is don't-care then).
  localparam int MEM_ENTRIES = (1 << VC_W) * DEPTH;

  logic [DATA_WIDTH-1:0] mem [MEM_ENTRIES];

  logic [ADDR_WIDTH-1:0] wr_ptr [NUM_VC];
  logic [ADDR_WIDTH-1:0] rd_ptr [NUM_VC];
  logic [NUM_VC-1:0]     push_sel;
  logic [NUM_VC-1:0]     pop_sel;
  logic [NUM_VC-1:0]     push_ok;
  logic [ADDR_WIDTH-1:0] wr_ptr_sel;
  logic [ADDR_WIDTH-1:0] rd_ptr_sel;
  logic                  push_accept;

  // A push_vc/pop_vc of NUM_VC or above matches no VC, so the request reaches
  // no controller and is ignored.
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign push_sel[v] = push && (push_vc == VC_W'(v));
    assign pop_sel[v]  = pop && (pop_vc == VC_W'(v));

    vc_fifo_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ctrl (
      .clk       (clk),
      .reset     (reset),
      .push      (push_sel[v]),
      .pop       (pop_sel[v]),
      .wr_ptr    (wr_ptr[v]),
      .rd_ptr    (rd_ptr[v]),
      .empty     (empty[v]),
      .full      (full[v]),
      .push_ok   (push_ok[v])
`ifdef VC_FIFO_COUNT_EN
      ,
      .occupancy (count[v*(ADDR_WIDTH+1) +: ADDR_WIDTH+1])
`endif
    );
  end

  // Pick the write pointer of the push target and the read pointer of the
  // displayed VC.
  always_comb begin
    wr_ptr_sel = '0;
    rd_ptr_sel = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (push_vc == VC_W'(v)) wr_ptr_sel = wr_ptr[v];
      if (pop_vc == VC_W'(v))  rd_ptr_sel = rd_ptr[v];
    end
  end

  assign push_accept = |push_ok;
  assign dout        = mem[{pop_vc, rd_ptr_sel}];

  // Storage has no reset; a write during reset is suppressed so reset wins
  // over a simultaneous push.
  always_ff @(posedge clk) begin
    if (!reset && push_accept) begin
      mem[{push_vc, wr_ptr_sel}] <= din;
    end
  end

  // Any push that no controller accepted was discarded: full target without a
  // same-VC pop, or an out-of-range target.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop <= 1'b0;
    end else begin
      drop <= push && !push_accept;
    end
  end

endmodule

// File: tb/tb_vc_fifo.sv
// tb_vc_fifo: self-checking bench for vc_fifo (NUM_VC=2, ADDR_WIDTH=3,
// DATA_WIDTH=32). A per-VC scoreboard queue holds the flits expected from each
// VC; entries are pushed when a write is accepted and popped and compared
// when a read is accepted. Flags and drop come from the same reference model.
module tb_vc_fifo;
  import noc_pkg::*;

  localparam int NV    = 2;
  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic [0:0]  push_vc;
  flit_t       din;
  logic        pop;
  logic [0:0]  pop_vc;
  flit_t       dout;
  logic [1:0]  empty;
  logic [1:0]  full;
  logic        drop;
`ifdef VC_FIFO_COUNT_EN
  logic [NV*(AW+1)-1:0] count;
`endif

  flit_t q0[$];
  flit_t q1[$];
  logic  exp_drop;
  int    test_count = 0;
  int    fail_count = 0;

  vc_fifo #(
    .NUM_VC     (NV),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_vc (push_vc),
    .din     (din),
    .pop     (pop),
    .pop_vc  (pop_vc),
    .dout    (dout),
    .empty   (empty),
    .full    (full),
    .drop    (drop)
`ifdef VC_FIFO_COUNT_EN
    ,
    .count   (count)
`endif
  );

  always #5 clk = ~clk;

  function automatic int sb_size(input int vc);
    return (vc == 0) ? q0.size() : q1.size();
  endfunction

  function automatic flit_t sb_front(input int vc);
    return (vc == 0) ? q0[0] : q1[0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every registered output, plus the head shown on dout, against
  // the model.
  task automatic checkOutput();
    logic [1:0] exp_empty;
    logic [1:0] exp_full;
    for (int v = 0; v < NV; v++) begin
      exp_empty[v] = (sb_size(v) == 0);
      exp_full[v]  = (sb_size(v) == DEPTH);
    end
    check("empty", 32'(empty), 32'(exp_empty));
    check("full", 32'(full), 32'(exp_full));
    check("drop", 32'(drop), 32'(exp_drop));
    if (sb_size(int'(pop_vc)) != 0) check("head", dout, sb_front(int'(pop_vc)));
`ifdef VC_FIFO_COUNT_EN
    for (int v = 0; v < NV; v++) begin
      check("count", 32'(count[v*(AW+1) +: AW+1]), 32'(sb_size(v)));
    end
`endif
  endtask

  // Drive one cycle of requests, predict acceptance independently of the DUT,
  // compare popped data before the edge and all state after it.
  task automatic applyStimulus(input logic p, input int pvc, input flit_t d,
                               input logic o, input int ovc);
    logic push_acc;
    logic pop_acc;
    push    = p;
    push_vc = 1'(pvc);
    din     = d;
    pop     = o;
    pop_vc  = 1'(ovc);
    push_acc = p && (sb_size(pvc) < DEPTH || (o && ovc == pvc));
    pop_acc  = o && (sb_size(ovc) > 0);
    #1;
    if (pop_acc) check("pop_data", dout, sb_front(ovc));
    @(posedge clk);
    #1;
    if (pop_acc) begin
      if (ovc == 0) void'(q0.pop_front());
      else          void'(q1.pop_front());
    end
    if (push_acc) begin
      if (pvc == 0) q0.push_back(d);
      else          q1.push_back(d);
    end
    exp_drop = p && !push_acc;
    checkOutput();
  endtask

  task automatic applyReset(input logic with_push);
    reset   = 1'b1;
    push    = with_push;
    push_vc = 1'b0;
    din     = 32'hDEAD_BEEF;
    pop     = with_push;
    pop_vc  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    q0.delete();
    q1.delete();
    exp_drop = 1'b0;
    checkOutput();
  endtask

  initial begin
    reset    = 1'b1;
    push     = 1'b0;
    push_vc  = '0;
    din      = '0;
    pop      = 1'b0;
    pop_vc   = '0;
    exp_drop = 1'b0;
    @(posedge clk);
    #1;

    // Reset state.
    applyReset(1'b0);

    // Fill VC0, then overflow it.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 0, flit_t'(i), 1'b0, 0);
    check("vc0_full", 32'(full[0]), 32'd1);
    check("vc1_empty", 32'(empty[1]), 32'd1);
    applyStimulus(1'b1, 0, 32'd8, 1'b0, 0);
    check("overflow_head", dout, 32'd0);
    applyStimulus(1'b0, 0, 32'd0, 1'b0, 0);

    // Push and pop the full VC0 together, then drain it.
    applyStimulus(1'b1, 0, 32'd8, 1'b1, 0);
    check("full_kept", 32'(full[0]), 32'd1);
    check("head_after", dout, 32'd1);
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b0, 0, 32'd0, 1'b1, 0);
    check("vc0_drained", 32'(empty[0]), 32'd1);
    applyStimulus(1'b0, 0, 32'd0, 1'b1, 0);

    // Different VCs in one cycle.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 0, 32'h100 + i, 1'b0, 0);
    applyStimulus(1'b1, 1, 32'hA, 1'b1, 0);
    applyStimulus(1'b0, 0, 32'd0, 1'b0, 1);
    check("vc1_head", dout, 32'hA);

    // Same empty VC pushed and popped together.
    applyStimulus(1'b0, 0, 32'd0, 1'b1, 1);
    applyStimulus(1'b1, 1, 32'h55, 1'b1, 1);
    check("vc1_not_empty", 32'(empty[1]), 32'd0);
    check("vc1_kept", dout, 32'h55);

    // Reset mid-operation with 5 entries in VC0, with a push/pop pending.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 0, 32'h200 + i, 1'b0, 0);
    check("vc0_five", 32'(sb_size(0)), 32'd5);
    applyReset(1'b1);
    applyStimulus(1'b0, 0, 32'd0, 1'b1, 0);

    // Mixed traffic with wrap-around, overflow and underflow.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), flit_t'($urandom),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
